// File: rtl/subst_equiv_sequencer.sv
// rtl/subst_equiv_sequencer.sv - exhaustive 8-input equivalence sweep of an original cone against its substituted form
module subst_equiv_sequencer #(
  parameter int SAMPLE_DELAY = 0,
  parameter bit STOP_ON_FAIL = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       dut_out,
  input  logic       ref_out,
  output logic [7:0] vec,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [8:0] mismatch_cnt,
  output logic [7:0] first_fail,
  output logic       fail_valid
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  // Keep at least one pipe slot so the zero-delay build still elaborates.
  localparam int PD = (SAMPLE_DELAY > 0) ? SAMPLE_DELAY : 1;

  state_t        state;
  logic [1:0]    drain_cnt;
  logic [PD-1:0] pipe_valid;
  logic [7:0]    pipe_vec [PD];
  logic          cmp_valid;
  logic [7:0]    cmp_vec;
  logic          hit;
  logic          active;
  logic          flush;
  logic [8:0]    cnt_next;

  always_comb begin
    active    = (state == RUN) || (state == DRAIN);
    cmp_valid = (SAMPLE_DELAY == 0) ? (state == RUN) : pipe_valid[PD-1];
    cmp_vec   = (SAMPLE_DELAY == 0) ? vec : pipe_vec[PD-1];
    hit       = active && !abort && cmp_valid && (dut_out != ref_out);
    cnt_next  = (hit && (mismatch_cnt != 9'd256)) ? mismatch_cnt + 9'd1 : mismatch_cnt;
    flush     = active && (abort || (STOP_ON_FAIL && hit));
  end

  // Delay line: the vector driven now is judged SAMPLE_DELAY cycles later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_valid <= '0;
      for (int i = 0; i < PD; i++) pipe_vec[i] <= 8'h00;
    end else if (flush) begin
      pipe_valid <= '0;
    end else begin
      for (int i = PD - 1; i > 0; i--) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_vec[i]   <= pipe_vec[i-1];
      end
      pipe_valid[0] <= (state == RUN);
      pipe_vec[0]   <= vec;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      drain_cnt    <= 2'd0;
      vec          <= 8'h00;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      mismatch_cnt <= 9'd0;
      first_fail   <= 8'h00;
      fail_valid   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !abort) begin
            state        <= RUN;
            busy         <= 1'b1;
            vec          <= 8'h00;
            pass         <= 1'b0;
            mismatch_cnt <= 9'd0;
            first_fail   <= 8'h00;
            fail_valid   <= 1'b0;
          end
        end
        RUN, DRAIN: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
            pass  <= 1'b0;
          end else begin
            mismatch_cnt <= cnt_next;
            if (hit && !fail_valid) begin
              first_fail <= cmp_vec;
              fail_valid <= 1'b1;
            end
            if (STOP_ON_FAIL && hit) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= 1'b0;
            end else if (state == RUN && vec != 8'hFF) begin
              vec <= vec + 8'd1;
            end else if (state == RUN && SAMPLE_DELAY > 0) begin
              state     <= DRAIN;
              drain_cnt <= 2'(SAMPLE_DELAY - 1);
            end else if (state == DRAIN && drain_cnt != 2'd0) begin
              drain_cnt <= drain_cnt - 2'd1;
            end else begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (cnt_next == 9'd0);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_subst_equiv_sequencer.sv
// tb/tb_subst_equiv_sequencer.sv - directed bench for the equivalence sweep sequencer
module tb_subst_equiv_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // u0: delay 0, u2: delay 2, us: delay 0 with stop-on-fail
  logic       start0 = 0, abort0 = 0, dut0, ref0;
  logic [7:0] vec0, ff0;
  logic       busy0, done0, pass0, fv0;
  logic [8:0] cnt0;
  logic       start2 = 0, abort2 = 0, dut2, ref2;
  logic [7:0] vec2, ff2;
  logic       busy2, done2, pass2, fv2;
  logic [8:0] cnt2;
  logic       starts = 0, aborts = 0, duts, refs;
  logic [7:0] vecs, ffs;
  logic       busys, dones, passs, fvs;
  logic [8:0] cnts;

  int   mode0 = 0;
  int   mode2 = 0;
  logic d1 = 1'b0, d2 = 1'b0;

  function automatic logic cone(input logic [7:0] v);
    return (v[7] & v[6] & ~v[5]) & (v[3] | v[2]);
  endfunction

  assign ref0 = cone(vec0);
  assign dut0 = (mode0 == 1) ? (cone(vec0) ^ (vec0 == 8'hC5)) : cone(vec0);
  always @(posedge clk) begin
    d1 <= cone(vec2);
    d2 <= d1;
  end
  assign dut2 = d2;
  assign ref2 = (mode2 == 1) ? cone(vec2) : d2;
  assign duts = 1'b1;
  assign refs = cone(vecs);

  subst_equiv_sequencer #(.SAMPLE_DELAY(0), .STOP_ON_FAIL(1'b0)) u0 (
    .clk(clk), .rst(rst), .start(start0), .abort(abort0), .dut_out(dut0), .ref_out(ref0),
    .vec(vec0), .busy(busy0), .done(done0), .pass(pass0), .mismatch_cnt(cnt0),
    .first_fail(ff0), .fail_valid(fv0));
  subst_equiv_sequencer #(.SAMPLE_DELAY(2), .STOP_ON_FAIL(1'b0)) u2 (
    .clk(clk), .rst(rst), .start(start2), .abort(abort2), .dut_out(dut2), .ref_out(ref2),
    .vec(vec2), .busy(busy2), .done(done2), .pass(pass2), .mismatch_cnt(cnt2),
    .first_fail(ff2), .fail_valid(fv2));
  subst_equiv_sequencer #(.SAMPLE_DELAY(0), .STOP_ON_FAIL(1'b1)) us (
    .clk(clk), .rst(rst), .start(starts), .abort(aborts), .dut_out(duts), .ref_out(refs),
    .vec(vecs), .busy(busys), .done(dones), .pass(passs), .mismatch_cnt(cnts),
    .first_fail(ffs), .fail_valid(fvs));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic done_of(input int sel);
    return (sel == 0) ? done0 : (sel == 2) ? done2 : dones;
  endfunction

  // Pulse start for one edge and count edges (accepting edge = 1) until done is seen.
  task automatic sweep(input int sel, output int n);
    if (sel == 0) start0 = 1; else if (sel == 2) start2 = 1; else starts = 1;
    tick();
    start0 = 0; start2 = 0; starts = 0;
    n = 1;
    while (!done_of(sel) && n < 600) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_vec0(input logic [7:0] v, input string tag);
    int k = 0;
    while (vec0 !== v && k < 400) begin
      tick();
      k++;
    end
    chk(tag, 32'(vec0), 32'(v));
  endtask

  int n;
  int seen;

  initial begin
    tick();
    tick();
    chk("rst_vec", 32'(vec0), 32'h00);
    chk("rst_busy", 32'(busy0), 32'h0);
    chk("rst_done", 32'(done0), 32'h0);
    chk("rst_pass", 32'(pass0), 32'h0);
    chk("rst_cnt", 32'(cnt0), 32'h0);
    chk("rst_fv", 32'(fv0), 32'h0);
    rst = 0;
    tick();

    mode0 = 0;
    sweep(0, n);
    chk("eq_lat", 32'(n), 32'd257);
    chk("eq_pass", 32'(pass0), 32'h1);
    chk("eq_cnt", 32'(cnt0), 32'h0);
    chk("eq_fv", 32'(fv0), 32'h0);
    chk("eq_vec", 32'(vec0), 32'hFF);
    tick();
    chk("eq_done_pulse", 32'(done0), 32'h0);
    chk("eq_pass_held", 32'(pass0), 32'h1);

    mode0 = 1;
    sweep(0, n);
    chk("c5_lat", 32'(n), 32'd257);
    chk("c5_cnt", 32'(cnt0), 32'h1);
    chk("c5_ff", 32'(ff0), 32'hC5);
    chk("c5_fv", 32'(fv0), 32'h1);
    chk("c5_pass", 32'(pass0), 32'h0);
    mode0 = 0;
    tick();

    mode2 = 0;
    sweep(2, n);
    chk("d2_lat", 32'(n), 32'd259);
    chk("d2_pass", 32'(pass2), 32'h1);
    chk("d2_cnt", 32'(cnt2), 32'h0);
    tick();
    mode2 = 1;
    sweep(2, n);
    chk("d2u_lat", 32'(n), 32'd259);
    chk("d2u_pass", 32'(pass2), 32'h0);
    chk("d2u_cnt_nz", 32'(cnt2 != 9'd0), 32'h1);
    chk("d2u_fv", 32'(fv2), 32'h1);

    sweep(1, n);
    chk("sf_lat", 32'(n), 32'd2);
    chk("sf_ff", 32'(ffs), 32'h00);
    chk("sf_cnt", 32'(cnts), 32'h1);
    chk("sf_pass", 32'(passs), 32'h0);
    chk("sf_fv", 32'(fvs), 32'h1);
    tick();

    // start ignored mid-run, then abort at 0x40
    start0 = 1;
    tick();
    start0 = 0;
    wait_vec0(8'h10, "ab_reach10");
    start0 = 1;
    tick();
    start0 = 0;
    chk("ab_vec_unbroken", 32'(vec0), 32'h11);
    chk("ab_busy_run", 32'(busy0), 32'h1);
    wait_vec0(8'h40, "ab_reach40");
    abort0 = 1;
    tick();
    abort0 = 0;
    chk("ab_busy", 32'(busy0), 32'h0);
    chk("ab_pass", 32'(pass0), 32'h0);
    chk("ab_cnt", 32'(cnt0), 32'h0);
    seen = 0;
    for (int i = 0; i < 300; i++) begin
      if (done0 || busy0) seen = 1;
      tick();
    end
    chk("ab_no_done", 32'(seen), 32'h0);
    start0 = 1;
    abort0 = 1;
    tick();
    start0 = 0;
    abort0 = 0;
    chk("ab_start_both", 32'(busy0), 32'h0);

    // async reset mid-sweep
    start0 = 1;
    tick();
    start0 = 0;
    wait_vec0(8'h80, "rs_reach80");
    #2 rst = 1;
    #1;
    chk("rs_vec", 32'(vec0), 32'h00);
    chk("rs_busy", 32'(busy0), 32'h0);
    chk("rs_done", 32'(done0), 32'h0);
    chk("rs_cnt", 32'(cnt0), 32'h0);
    tick();
    rst = 0;
    seen = 0;
    for (int i = 0; i < 300; i++) begin
      if (done0 || busy0) seen = 1;
      tick();
    end
    chk("rs_no_done", 32'(seen), 32'h0);
    sweep(0, n);
    chk("rs_fresh_lat", 32'(n), 32'd257);
    chk("rs_fresh_pass", 32'(pass0), 32'h1);
    chk("rs_fresh_cnt", 32'(cnt0), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/subst_equiv_sequencer.md
SUBST_EQUIV_SEQUENCER -- requirements
Module: subst_equiv_sequencer

Interface
REQ-001 SHALL have parameter SAMPLE_DELAY, default 0, range 0..3: cycles from vector driven on vec to outputs valid on dut_out/ref_out.
REQ-002 SHALL have parameter STOP_ON_FAIL, default 0: 1 ends the sweep at the first mismatch.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  begin exhaustive sweep (sampled in IDLE only).
REQ-006 SHALL have port abort  input  1  cancel sweep in progress.
REQ-007 SHALL have port dut_out  input  1  output of the original 8-input cone under test.
REQ-008 SHALL have port ref_out  input  1  output of the simplified (substituted) cone.
REQ-009 SHALL have port vec  output  8  stimulus; bit7..bit0 drive inputs a..h.
REQ-010 SHALL have port busy  output  1  high in RUN and DRAIN.
REQ-011 SHALL have port done  output  1  one-cycle pulse at sweep completion.
REQ-012 SHALL have port pass  output  1  sticky result: 1 iff last completed sweep had zero mismatches.
REQ-013 SHALL have port mismatch_cnt  output  9  mismatches in current/last sweep (0..256).
REQ-014 SHALL have port first_fail  output  8  vector of the first mismatch.
REQ-015 SHALL have port fail_valid  output  1  first_fail holds a captured vector.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, DRAIN, DONE.
REQ-017 IDLE: start=1 and abort=0 -> RUN; on that edge clear mismatch_cnt, fail_valid, first_fail, pass, and set vec=0.
REQ-018 RUN: vec increments by 1 per cycle; in the cycle vec=255, next state is DRAIN if SAMPLE_DELAY>0, else DONE; vec holds 255 after RUN.
REQ-019 DRAIN: lasts exactly SAMPLE_DELAY cycles, then DONE.
REQ-020 DONE: lasts one cycle with done=1, then IDLE; pass=1 in DONE iff mismatch_cnt=0, held until next accepted start or reset.
REQ-021 Vector k (k-th RUN cycle, k=0..255) SHALL be compared in cycle k+SAMPLE_DELAY after RUN entry; an internal SAMPLE_DELAY-deep valid/vector delay line SHALL track in-flight vectors.
REQ-022 Compare cycle with dut_out!=ref_out: mismatch_cnt+1 (saturating at 256, 9-bit); if fail_valid=0, first_fail<=delayed vector and fail_valid<=1.
REQ-023 Exactly 256 comparisons per uninterrupted sweep; no comparison outside tracked slots.
REQ-024 STOP_ON_FAIL=1: first mismatch -> DONE next cycle, remaining in-flight slots discarded, mismatch_cnt=1, pass=0.
REQ-025 start while busy or in DONE SHALL be ignored.
REQ-026 abort in RUN/DRAIN -> IDLE next cycle, no done pulse, pass=0, mismatch_cnt/first_fail/fail_valid retain values, delay line flushed.
REQ-027 abort and start together in IDLE: abort wins, stay IDLE.
REQ-028 Sweep latency start-edge to done: 257+SAMPLE_DELAY cycles (256 RUN + DRAIN + 1 DONE).

Reset
REQ-029 rst=1 SHALL asynchronously force IDLE, vec=0, busy=0, done=0, pass=0, mismatch_cnt=0, first_fail=0, fail_valid=0, delay line invalid.
REQ-030 Reset mid-sweep SHALL discard the sweep with no done pulse; operation resumes only on a new start after rst deasserts.

Verification
REQ-031 SAMPLE_DELAY=0, dut=ref=(a&b&~c)&(e|f) -> done 257 cycles after start, pass=1, mismatch_cnt=0, fail_valid=0.
REQ-032 SAMPLE_DELAY=2, DUT registered 2 stages, ref also delayed 2 -> done at cycle 259, pass=1; ref undelayed -> pass=0, mismatch_cnt>0.
REQ-033 dut_out forced = ref_out XOR (vec==8'hC5) -> mismatch_cnt=1, first_fail=8'hC5, fail_valid=1, pass=0.
REQ-034 STOP_ON_FAIL=1, dut_out stuck 1, ref=a&b&~c&(e|f) -> first_fail=8'h00, mismatch_cnt=1, done 2 cycles after start.
REQ-035 abort at vec=8'h40 -> IDLE next cycle, no done, busy=0, pass=0; start during RUN ignored (vec sequence unbroken).
REQ-036 rst asserted at vec=8'h80 -> all outputs zero immediately (asynchronous), no done; fresh start completes normal sweep.
